comp_share_arb: RTL and testbench

- Shares a single registered 8-bit magnitude comparator (greater/equal/less flags) between N requesters.
- Requesters present operand pairs with a request line. A round-robin arbiter grants one at a time, captures its operands, compares them, and returns the flags with the requester ID over a valid/ready response channel.
- Sits between the comparator datapath and the blocks that need comparisons. Replaces per-requester comparator copies.

---
 rtl/comp_share_arb.sv | 91 +++++++++
 tb/tb_comp_share_arb.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/comp_share_arb.sv
// comp_share_arb: one registered W-bit comparator shared round-robin by N requesters
// Ports: clk, rst (sync, active-high); req/a_bus/b_bus per requester; gnt one-hot accept pulse;
// busy (not IDLE); rsp_valid/rsp_ready response handshake carrying rsp_id and rsp_gt/eq/lt.
// Optional: define COMP_SIGNED_EN to add cmp_signed, sampled at grant, for two's-complement compares.
module comp_share_arb #(
  parameter int N   = 4,
  parameter int W   = 8,
  parameter int IDW = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req,
  input  logic [N*W-1:0]   a_bus,
  input  logic [N*W-1:0]   b_bus,
  output logic [N-1:0]     gnt,
  output logic             busy,
  output logic             rsp_valid,
  input  logic             rsp_ready,
`ifdef COMP_SIGNED_EN
  input  logic             cmp_signed,
`endif
  output logic [IDW-1:0]   rsp_id,
  output logic             rsp_gt,
  output logic             rsp_eq,
  output logic             rsp_lt
);
  typedef enum logic [1:0] {IDLE, CMP, RSP} state_t;
  state_t state;
  logic [IDW-1:0] ptr, win;
  logic [W-1:0] a_r, b_r;
  logic gt, lt;
  // Scan farthest-to-nearest from ptr+1 so the nearest pending requester is the final assignment.
  always_comb begin
    win = ptr;
    for (int k = N; k >= 1; k--)
      if (req[(int'(ptr) + k) % N]) win = IDW'((int'(ptr) + k) % N);
  end
`ifdef COMP_SIGNED_EN
  logic sgn_r;
  assign gt = sgn_r ? $signed(a_r) > $signed(b_r) : a_r > b_r;
  assign lt = sgn_r ? $signed(a_r) < $signed(b_r) : a_r < b_r;
`else
  assign gt = a_r > b_r;
  assign lt = a_r < b_r;
`endif
  assign busy = state != IDLE;
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      gnt       <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_gt    <= 1'b0;
      rsp_eq    <= 1'b0;
      rsp_lt    <= 1'b0;
      ptr       <= IDW'(N - 1);
      a_r       <= '0;
      b_r       <= '0;
`ifdef COMP_SIGNED_EN
      sgn_r     <= 1'b0;
`endif
    end else begin
      gnt <= '0;
      case (state)
        IDLE: if (|req) begin
          a_r      <= a_bus[int'(win)*W +: W];
          b_r      <= b_bus[int'(win)*W +: W];
`ifdef COMP_SIGNED_EN
          sgn_r    <= cmp_signed;
`endif
          gnt[win] <= 1'b1;
          ptr      <= win;
          state    <= CMP;
        end
        CMP: begin
          rsp_gt    <= gt;
          rsp_eq    <= a_r == b_r;
          rsp_lt    <= lt;
          rsp_id    <= ptr;
          rsp_valid <= 1'b1;
          state     <= RSP;
        end
        RSP: if (rsp_ready) begin
          rsp_valid <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_comp_share_arb.sv
// tb_comp_share_arb: scoreboard bench for comp_share_arb with directed and random stimulus
module tb_comp_share_arb;
  localparam int N = 4, W = 8, IDW = 2;
  logic clk = 0, rst = 1, rsp_ready = 1, sgn = 0;
  logic [N-1:0] req = '0, dropped;
  logic [N*W-1:0] a_bus = '0, b_bus = '0;
  logic [N-1:0] gnt;
  logic busy, rsp_valid, rsp_gt, rsp_eq, rsp_lt;
  logic [IDW-1:0] rsp_id;
  int ncmp = 0, nerr = 0, cyc = 0;
  typedef struct {int id; int due;} g_t;
  typedef struct {int id; logic [2:0] f;} r_t;
  g_t eg[$];
  r_t er[$];
  int phase = 0, mptr = N - 1;
  comp_share_arb #(.N(N), .W(W), .IDW(IDW)) dut (
    .clk(clk), .rst(rst), .req(req), .a_bus(a_bus), .b_bus(b_bus), .gnt(gnt), .busy(busy),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
`ifdef COMP_SIGNED_EN
    .cmp_signed(sgn),
`endif
    .rsp_id(rsp_id), .rsp_gt(rsp_gt), .rsp_eq(rsp_eq), .rsp_lt(rsp_lt));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(string n, int act, int exp);
    ncmp++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", n, cyc, act, exp);
    end
  endtask
  // Reference model: predicts what the next rising edge does, using the inputs it will sample.
  // phase is the arbiter's position in its idle/compare/respond cycle after that edge.
  always @(negedge clk) begin
    if (rst) begin
      phase = 0;
      mptr = N - 1;
      eg.delete();
      er.delete();
    end else if (phase == 0 && req != 0) begin
      int w, sa, sb;
      r_t r;
      w = 0;
      for (int k = 1; k <= N; k++)
        if (req[(mptr + k) % N]) begin
          w = (mptr + k) % N;
          break;
        end
      sa = sgn ? int'($signed(a_bus[w*W +: W])) : int'(a_bus[w*W +: W]);
      sb = sgn ? int'($signed(b_bus[w*W +: W])) : int'(b_bus[w*W +: W]);
      r.id = w;
      r.f = {sa > sb, sa == sb, sa < sb};
      eg.push_back('{w, cyc + 1});
      er.push_back(r);
      mptr = w;
      phase = 1;
    end else if (phase == 1) phase = 2;
    else if (phase == 2 && rsp_ready) begin
      void'(er.pop_front());
      phase = 0;
    end
  end
  // Monitor: compares DUT outputs just after each edge against what the model predicted.
  always @(posedge clk) begin
    logic rst_s;
    logic [N-1:0] exp_g;
    rst_s = rst;
    #1;
    exp_g = '0;
    if (eg.size() != 0 && eg[0].due == cyc) begin
      exp_g[eg[0].id] = 1'b1;
      void'(eg.pop_front());
    end
    chk("gnt", int'(gnt), int'(exp_g));
    chk("busy", int'(busy), int'(phase != 0));
    chk("rsp_valid", int'(rsp_valid), int'(phase == 2));
    if (rsp_valid && er.size() != 0) begin
      chk("rsp_id", int'(rsp_id), er[0].id);
      chk("rsp_flags", int'({rsp_gt, rsp_eq, rsp_lt}), int'(er[0].f));
    end
    if (rst_s) chk("reset_rsp", int'({rsp_id, rsp_gt, rsp_eq, rsp_lt}), 0);
  end
  task automatic tick();
    @(posedge clk);
    #2;
    dropped = req & gnt;
    req = req & ~gnt;
  endtask
  task automatic set_op(int i, logic [W-1:0] a, logic [W-1:0] b);
    a_bus[i*W +: W] = a;
    b_bus[i*W +: W] = b;
  endtask
  task automatic wait_idle();
    int n = 0;
    while ((req != 0 || phase != 0) && n < 300) begin
      tick();
      n++;
    end
    if (n >= 300) chk("idle_timeout", 1, 0);
  endtask
  task automatic wait_valid();
    int n = 0;
    while (!rsp_valid && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) chk("valid_timeout", 1, 0);
  endtask
  task automatic op(int i, logic [W-1:0] a, logic [W-1:0] b);
    set_op(i, a, b);
    req[i] = 1'b1;
    wait_idle();
  endtask
  initial begin
    tick();
    tick();
    rst = 0;
    tick();
    op(0, 8'd200, 8'd100);
    op(1, 8'd55, 8'd55);
    op(2, 8'd3, 8'd250);
    for (int i = 0; i < N; i++) set_op(i, W'($urandom), W'($urandom));
    req = 4'b1111;
    wait_idle();
    req = 4'b1001;
    wait_idle();
    rsp_ready = 0;
    set_op(0, 8'd9, 8'd10);
    req[0] = 1'b1;
    wait_valid();
    set_op(1, 8'd77, 8'd7);
    req[1] = 1'b1;
    repeat (5) tick();
    rsp_ready = 1;
    wait_idle();
    rsp_ready = 0;
    set_op(2, 8'd1, 8'd1);
    req[2] = 1'b1;
    wait_valid();
    rst = 1;
    tick();
    rst = 0;
    rsp_ready = 1;
    tick();
    op(3, 8'hFF, 8'h00);
    set_op(1, 8'd4, 8'd5);
    set_op(3, 8'd6, 8'd5);
    req = 4'b1010;
    wait_idle();
`ifdef COMP_SIGNED_EN
    sgn = 1;
    op(0, 8'hFF, 8'h01);
    sgn = 0;
    op(0, 8'hFF, 8'h01);
`endif
    for (int t = 0; t < 2000; t++) begin
      tick();
      rsp_ready = $urandom_range(3) != 0;
`ifdef COMP_SIGNED_EN
      sgn = $urandom_range(1) == 1;
`endif
      for (int i = 0; i < N; i++)
        if (!req[i] && !dropped[i] && $urandom_range(3) == 0) begin
          logic [W-1:0] a;
          a = W'($urandom);
          set_op(i, a, ($urandom_range(3) == 0) ? a : W'($urandom));
          req[i] = 1'b1;
        end
    end
    rsp_ready = 1;
    wait_idle();
    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
